// File: rtl/regfile.sv
// RV32I integer register file: x1..x31 in flops, x0 reads as zero.
// Two combinational read ports with write-through forwarding from the single write port.
module regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic [ADDR_W-1:0] a_rs1,
    output logic [DATA_W-1:0] d_rs1,
    input  logic [ADDR_W-1:0] a_rs2,
    output logic [DATA_W-1:0] d_rs2,
    input  logic [ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0] d_rd,
    input  logic              we_rd
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [1:NREG-1];
    logic              wr_active;

    // A write only exists out of reset and to a real register; this also gates forwarding.
    assign wr_active = resetb && we_rd && (a_rd != '0);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            for (int i = 1; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_active) begin
            regs[a_rd] <= d_rd;
        end
    end

    always_comb begin
        d_rs1 = '0;
        if (resetb) begin
            if (wr_active && (a_rs1 == a_rd)) begin
                d_rs1 = d_rd;
            end else if (a_rs1 != '0) begin
                d_rs1 = regs[a_rs1];
            end
        end
    end

    always_comb begin
        d_rs2 = '0;
        if (resetb) begin
            if (wr_active && (a_rs2 == a_rd)) begin
                d_rs2 = d_rd;
            end else if (a_rs2 != '0) begin
                d_rs2 = regs[a_rs2];
            end
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Bench for regfile: directed scenarios with literal expectations plus random traffic,
// all checked every cycle against an array model of the architectural registers.
module tb_regfile;

    logic        clk = 1'b0;
    logic        resetb;
    logic [4:0]  a_rs1, a_rs2, a_rd;
    logic [31:0] d_rs1, d_rs2, d_rd;
    logic        we_rd;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] model [32] = '{default: 32'h0};

    regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk    (clk),
        .resetb (resetb),
        .a_rs1  (a_rs1),
        .d_rs1  (d_rs1),
        .a_rs2  (a_rs2),
        .d_rs2  (d_rs2),
        .a_rd   (a_rd),
        .d_rd   (d_rd),
        .we_rd  (we_rd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Architectural view: what a read of addr must return given the current inputs.
    function automatic logic [31:0] expect_read(input logic [4:0] addr);
        if (resetb !== 1'b1) return 32'h0;
        if (addr == 5'd0) return 32'h0;
        if (we_rd && a_rd == addr) return d_rd;
        return model[addr];
    endfunction

    always @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (we_rd && a_rd != 5'd0) begin
            model[a_rd] = d_rd;
        end
    end

    always @(negedge clk) begin
        check("model_rs1", d_rs1, expect_read(a_rs1));
        check("model_rs2", d_rs2, expect_read(a_rs2));
    end

    task automatic drive(input logic [4:0] rd, input logic [31:0] dd, input logic we,
                         input logic [4:0] r1, input logic [4:0] r2);
        @(posedge clk);
        #1;
        a_rd  = rd;
        d_rd  = dd;
        we_rd = we;
        a_rs1 = r1;
        a_rs2 = r2;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 resetb = 1'b0;
        we_rd = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 resetb = 1'b1;
    endtask

    initial begin
        resetb = 1'b0;
        a_rs1 = '0; a_rs2 = '0; a_rd = '0; d_rd = '0; we_rd = 1'b0;
        #3 check("reset_rs1", d_rs1, 32'h0);
        do_reset();

        // Asynchronous clear of a written register.
        drive(5'd5, 32'hDEADBEEF, 1'b1, 5'd0, 5'd0);
        drive(5'd0, 32'h0, 1'b0, 5'd5, 5'd5);
        #3 check("x5_written", d_rs1, 32'hDEADBEEF);
        @(posedge clk);
        #2 resetb = 1'b0;
        #1 check("async_clear", d_rs1, 32'h0);
        @(posedge clk);
        #2 resetb = 1'b1;
        #1 check("after_release", d_rs1, 32'h0);

        // Sequential write/read with a lag of one and two.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            drive(5'(i), 32'(32 - (i % 32)), 1'b1, 5'(i - 1), 5'(i - 2));
            #3;
            if (i == 0) begin
                check("lag_i0_rs1", d_rs1, 32'h0);
                check("lag_i0_rs2", d_rs2, 32'h0);
            end
            if (i == 1) check("lag_i1_rs1", d_rs1, 32'h0);
            if (i == 2) begin
                check("lag_i2_rs1", d_rs1, 32'd31);
                check("lag_i2_rs2", d_rs2, 32'h0);
            end
            if (i == 3) check("lag_i3_rs2", d_rs2, 32'd31);
            if (i == 33) begin
                check("lag_i33_rs2", d_rs2, 32'd1);
                check("lag_i33_rs1", d_rs1, 32'h0);
            end
        end

        // Forwarding from the write port in the same cycle.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(5'(i), 32'(32 - i), 1'b1, 5'(i), 5'(i - 1));
            #3;
            if (i == 0) check("fwd_i0_rs1", d_rs1, 32'h0);
            if (i == 1) begin
                check("fwd_i1_rs1", d_rs1, 32'd31);
                check("fwd_i1_rs2", d_rs2, 32'h0);
            end
            if (i == 2) begin
                check("fwd_i2_rs1", d_rs1, 32'd30);
                check("fwd_i2_rs2", d_rs2, 32'd31);
            end
        end

        // Write enable low must not write or forward.
        drive(5'd7, 32'h0000_0077, 1'b1, 5'd0, 5'd0);
        drive(5'd7, 32'h0000_1234, 1'b0, 5'd7, 5'd7);
        #3 check("we_low_before", d_rs1, 32'h0000_0077);
        @(posedge clk);
        #1 check("we_low_after", d_rs1, 32'h0000_0077);

        // Both ports on the write target.
        drive(5'd9, 32'hA5A5A5A5, 1'b1, 5'd9, 5'd9);
        #3 check("dual_fwd_rs1", d_rs1, 32'hA5A5A5A5);
        check("dual_fwd_rs2", d_rs2, 32'hA5A5A5A5);
        drive(5'd0, 32'h0, 1'b0, 5'd9, 5'd9);
        #3 check("dual_store_rs1", d_rs1, 32'hA5A5A5A5);
        check("dual_store_rs2", d_rs2, 32'hA5A5A5A5);

        // Write attempted while reset is held.
        @(posedge clk);
        #2 resetb = 1'b0;
        a_rd = 5'd3; d_rd = 32'hFF; we_rd = 1'b1; a_rs1 = 5'd3; a_rs2 = 5'd9;
        #1 check("rst_no_fwd", d_rs1, 32'h0);
        @(posedge clk);
        #2 resetb = 1'b1;
        we_rd = 1'b0;
        @(posedge clk);
        #1 check("rst_write_dropped", d_rs1, 32'h0);

        // Random traffic with occasional reset pulses.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] rd;
            rd = 5'($urandom_range(0, 31));
            drive(rd, $urandom, ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 99) == 0) resetb = 1'b0;
            else resetb = 1'b1;
        end
        drive(5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
        resetb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- Integer register file for the RV32I embedded softcore: 32 registers x0..x31, 32 bits each.
- Two combinational read ports (rs1, rs2) feed the decode/execute stage.
- One synchronous write port (rd) is driven by writeback.
- x0 is hardwired to zero. A write to a register that is being read in the same cycle is forwarded to the read port.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; register count = 2**ADDR_W = 32.

Ports:
- clk  input  1  clock; all writes occur on the rising edge.
- resetb  input  1  asynchronous, active-low reset.
- a_rs1  input  ADDR_W  read port 1 address.
- d_rs1  output  DATA_W  read port 1 data (combinational).
- a_rs2  input  ADDR_W  read port 2 address.
- d_rs2  output  DATA_W  read port 2 data (combinational).
- a_rd  input  ADDR_W  write address.
- d_rd  input  DATA_W  write data.
- we_rd  input  1  write enable, active high.

Behaviour:
- Clock and reset: one clock, clk. Reset resetb is asynchronous and active-low.
- Storage: registers x1..x31 are flops. x0 has no storage; reads of x0 always return 0.
- Reset: while resetb=0, x1..x31 are cleared to 0 immediately, independent of clk, and held at 0.
  - Writes are ignored while resetb=0.
  - Forwarding is disabled while resetb=0, so d_rs1/d_rs2 read 0 for every address during reset.
  - Reset asserted mid-operation discards any write pending on that edge.
- Write: on a rising clk edge with resetb=1, we_rd=1 and a_rd!=0, register[a_rd] <= d_rd.
  - a_rd=0 is a no-op.
  - we_rd=0 leaves all registers unchanged.
- Read: d_rsN is purely combinational from a_rsN, register contents, and the forwarding inputs. There are no read-enable inputs and no read latency.
- Forwarding (write-through): if resetb=1, we_rd=1, a_rd!=0 and a_rsN==a_rd, then d_rsN=d_rd in the same cycle, before the clock edge.
  - Applies independently to both ports; both may forward at once.
  - Otherwise d_rsN = register[a_rsN], or 0 when a_rsN=0.
- Timing: a value written at edge N is visible through storage from edge N onward. Through forwarding it is already visible in the cycle before edge N.
- Both read ports may address the same register, including the write target. Results are identical on both ports.
- Addresses wrap naturally at 5 bits; no out-of-range case exists.
- Outputs never drive X once reset has been applied.

Test Plan:
- Reset clear: write x5=0xDEADBEEF, then pulse resetb low between clock edges -> d_rs1 with a_rs1=5 reads 0 immediately (asynchronous), and still 0 after release.
- Sequential R/W with lag (after reset, for i=0..39): a_rd=i mod 32, d_rd=32-(i mod 32), we_rd=1, a_rs1=i-1, a_rs2=i-2 -> expected values:
  - i=0: d_rs1 (x31) = 0, d_rs2 (x30) = 0.
  - i=1: d_rs1 (x0) = 0 (the write of 32 to x0 is discarded).
  - i=2: d_rs1 (x1) = 31, d_rs2 (x0) = 0.
  - i=3: d_rs2 (x1) = 31.
  - i=33: d_rs2 (x31) = 1; d_rs1 (x0) = 0 despite the x0 write at i=32.
- Forwarding (after reset, same loop but a_rs1=i, a_rs2=i-1):
  - i=0: d_rs1 = 0.
  - i=1: d_rs1 = 31 before the edge, d_rs2 = 0.
  - i=2: d_rs1 = 30, d_rs2 = 31.
- Write-enable gating: we_rd=0, a_rd=a_rs1=7, d_rd=0x1234 -> d_rs1 keeps the prior x7 value, both before and after the edge.
- Dual-port same address: a_rs1=a_rs2=a_rd=9, we_rd=1, d_rd=0xA5A5A5A5 -> both ports read 0xA5A5A5A5 in the same cycle and after the edge.
- Write during reset: resetb=0, we_rd=1, a_rd=3, d_rd=0xFF across an edge -> after release x3 reads 0.
